ps2_key_tracker: RTL and testbench
==================================

# ps2_key_tracker

Converts the raw PS/2 byte stream from `PS2_Controller` into decoded key make/break events and per-key held state for the dinosaur game. It sits between `PS2_Controller` and the jump/physics logic. It resolves `E0` (extended) and `F0` (break) prefixes, suppresses typematic repeats, and emits one-cycle press pulses for gameplay actions.

## Interface
- `PREFIX_TIMEOUT`, default 100000: number of cycles a prefix state may wait for its next byte before aborting (2 ms at 50 MHz).
- `CLOCK_50`  in  1  system clock; all logic on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low (driven from `KEY[0]`).
- `ps2_data`  in  8  received byte; valid only while `ps2_data_en` is high.
- `ps2_data_en`  in  1  one-cycle strobe per received byte.
- `event_valid`  out  1  one-cycle pulse when a complete make or break code is decoded.
- `event_break`  out  1  qualifies `event_valid`: 1 = break, 0 = make.
- `event_ext`  out  1  qualifies `event_valid`: 1 = code was `E0`-prefixed.
- `event_code`  out  8  final, non-prefix byte of the event; holds its value until the next event.
- `jump_held`  out  1  Space (`29`) or Up (`E0 75`) currently held.
- `duck_held`  out  1  Down (`E0 72`) currently held.
- `start_held`  out  1  Enter (`5A`) currently held.
- `jump_press`  out  1  one-cycle pulse when `jump_held` goes 0→1.
- `start_press`  out  1  one-cycle pulse when `start_held` goes 0→1.
- `proto_error`  out  1  one-cycle pulse on a prefix violation or a timeout.

## Operation
- Reset value of every output is 0. Internal state on reset: FSM in `IDLE`, timer = 0, all internal held bits = 0.
- FSM has four states: `IDLE`, `EXT`, `BRK`, `EXT_BRK`. It advances only on cycles where `ps2_data_en` = 1, except for the timeout.
- Ignored bytes: `00 AA EE FA FE FF E1`.
  - In `IDLE`, an ignored byte is dropped with no state change.
  - In any prefix state, an ignored byte causes `proto_error` and a transition to `IDLE`.
- `IDLE` transitions:
  - `E0` → `EXT`.
  - `F0` → `BRK`.
  - Any other byte → make event with ext=0; stay in `IDLE`.
- `EXT` transitions:
  - `F0` → `EXT_BRK`.
  - `E0` → `proto_error`, stay in `EXT`, restart the timer.
  - Any other byte → make event with ext=1; go to `IDLE`.
- `BRK` transitions:
  - Non-prefix byte → break event with ext=0; go to `IDLE`.
  - `E0` or `F0` → `proto_error`; go to `IDLE`.
- `EXT_BRK` transitions:
  - Non-prefix byte → break event with ext=1; go to `IDLE`.
  - `E0` or `F0` → `proto_error`; go to `IDLE`.
- Timeout:
  - In a non-`IDLE` state, the timer counts every cycle and resets on each accepted byte.
  - When the timer reaches `PREFIX_TIMEOUT-1`, the FSM goes to `IDLE` and pulses `proto_error`.
  - If a byte arrives in the same cycle the timer expires, the byte wins and is decoded in the current state.
- Held tracking: there are separate internal bits for Space, Up, Down and Enter.
  - A make of the key sets its bit; a break clears it.
  - A break for a key that is not held is harmless.
  - `jump_held` = Space | Up.
- Typematic repeats: a repeated make of a key that is already held updates `event_*` but does not pulse `*_press`.
- Press pulses:
  - `jump_press` fires only when `jump_held` was 0 before the event and is 1 after it.
  - Pressing Up while Space is already held gives no pulse.
- Unmapped keys generate events only; they do not affect any held bit.

## Timing
- All outputs are registered.
- Latency: `event_valid`, the `*_press` pulses and the held-state changes appear on the cycle after the `ps2_data_en` cycle that carried the final byte.
- A `proto_error` caused by a byte follows the same latency. A `proto_error` caused by timeout is asserted on the cycle after expiry.
- Strobes on back-to-back cycles must be accepted; there is no backpressure.
- When `resetn` asserts mid-sequence, all outputs and held bits clear immediately (asynchronously). No event is produced for a partial sequence.

## Structure
- Shared package `ps2_keys_pkg` holds:
  - the scancode constants (`SC_EXT`=`E0`, `SC_BRK`=`F0`, `SC_SPACE`, `SC_UP`, `SC_DOWN`, `SC_ENTER`);
  - the ignored-byte list;
  - the FSM state encoding.
- No sub-module. The timer and the key map stay inline in a single module.

## Test plan
- `29` → `event_valid` with code=29, break=0, ext=0; `jump_held`=1; `jump_press` pulses once. Then `29 29` (repeat) → two more events, no further `jump_press`. Then `F0 29` → break event; `jump_held`=0.
- `E0 75`, then `29`, then `E0 F0 75` → `jump_press` fires once only; `jump_held` stays 1 until `F0 29`.
- `E0 72` → `duck_held`=1 with ext=1. `E0 F0 72` → `duck_held`=0. Bytes strobed on consecutive cycles decode identically.
- `F0`, then idle for `PREFIX_TIMEOUT` cycles → `proto_error` pulse, FSM back in `IDLE`. A subsequent `5A` → make event, `start_press` pulse.
- `E0 E0 75` → one `proto_error` pulse, then a make event with ext=1, code=75. `F0 E0` → `proto_error` with no event.
- Assert `resetn` low after `E0 F0` while `jump_held`=1 → all outputs 0. A following `75` decodes as a non-extended make.

Source files
------------

// File: rtl/ps2_keys_pkg.sv
// ps2_keys_pkg
// Shared definitions for the PS/2 key tracker: scancode constants, the
// ignored-byte classifier and the prefix-decoder state encoding.
package ps2_keys_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;  // E0-prefixed
  localparam logic [7:0] SC_DOWN  = 8'h72;  // E0-prefixed
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // Keyboard housekeeping bytes (ACK, BAT result, echo, resend, errors,
  // Pause prefix) that never form part of a make/break code.
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1: is_ignored = 1'b1;
      default:                                          is_ignored = 1'b0;
    endcase
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

endpackage

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
// Decodes the PS/2 byte stream into make/break events, tracks the held state
// of the game keys and produces one-cycle press pulses.
// Ports:
//   CLOCK_50     in   system clock (rising edge)
//   resetn       in   asynchronous active-low reset
//   ps2_data     in   received byte, qualified by ps2_data_en
//   ps2_data_en  in   one-cycle strobe per byte
//   event_*      out  decoded event pulse and its qualifiers / code
//   *_held       out  current held state of jump / duck / start
//   *_press      out  one-cycle pulse on held 0->1
//   proto_error  out  one-cycle pulse on prefix violation or timeout
module ps2_key_tracker
  import ps2_keys_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] ps2_data,
  input  logic       ps2_data_en,
  output logic       event_valid,
  output logic       event_break,
  output logic       event_ext,
  output logic [7:0] event_code,
  output logic       jump_held,
  output logic       duck_held,
  output logic       start_held,
  output logic       jump_press,
  output logic       start_press,
  output logic       proto_error
);

  localparam int TW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(PREFIX_TIMEOUT - 1);

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_space, r_up, r_down, r_enter;
  logic          w_space_nxt, w_up_nxt, w_down_nxt, w_enter_nxt;
  logic          w_evt, w_brk, w_ext, w_err;
  logic          w_jump_old, w_jump_new;

  logic          r_event_valid, r_event_break, r_event_ext;
  logic [7:0]    r_event_code;
  logic          r_jump_held, r_jump_press, r_start_press, r_proto_error;

  // Prefix decoder: a byte on the strobe always wins over a timeout that
  // would expire in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_evt       = 1'b0;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    w_err       = 1'b0;
    if (ps2_data_en) begin
      w_timer_nxt = '0;
      case (r_state)
        ST_IDLE: begin
          if (is_ignored(ps2_data)) begin
            w_state_nxt = ST_IDLE;
          end else if (ps2_data == SC_EXT) begin
            w_state_nxt = ST_EXT;
          end else if (ps2_data == SC_BRK) begin
            w_state_nxt = ST_BRK;
          end else begin
            w_evt = 1'b1;
          end
        end
        ST_EXT: begin
          if (is_ignored(ps2_data)) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (ps2_data == SC_BRK) begin
            w_state_nxt = ST_EXT_BRK;
          end else if (ps2_data == SC_EXT) begin
            // Duplicate E0: flag it but keep waiting for the real code.
            w_err = 1'b1;
          end else begin
            w_evt       = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          w_state_nxt = ST_IDLE;
          if (is_ignored(ps2_data) || ps2_data == SC_EXT || ps2_data == SC_BRK) begin
            w_err = 1'b1;
          end else begin
            w_evt = 1'b1;
            w_brk = 1'b1;
            w_ext = (r_state == ST_EXT_BRK);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE) begin
      if (r_timer == TIMER_LAST) begin
        w_err       = 1'b1;
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end else begin
        w_timer_nxt = r_timer + TW'(1);
      end
    end
  end

  // Key map: only the four game keys own a held bit.
  always_comb begin
    w_space_nxt = r_space;
    w_up_nxt    = r_up;
    w_down_nxt  = r_down;
    w_enter_nxt = r_enter;
    if (w_evt) begin
      if (!w_ext && ps2_data == SC_SPACE) w_space_nxt = ~w_brk;
      if ( w_ext && ps2_data == SC_UP)    w_up_nxt    = ~w_brk;
      if ( w_ext && ps2_data == SC_DOWN)  w_down_nxt  = ~w_brk;
      if (!w_ext && ps2_data == SC_ENTER) w_enter_nxt = ~w_brk;
    end
    w_jump_old = r_space | r_up;
    w_jump_new = w_space_nxt | w_up_nxt;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_space       <= 1'b0;
      r_up          <= 1'b0;
      r_down        <= 1'b0;
      r_enter       <= 1'b0;
      r_event_valid <= 1'b0;
      r_event_break <= 1'b0;
      r_event_ext   <= 1'b0;
      r_event_code  <= 8'h00;
      r_jump_held   <= 1'b0;
      r_jump_press  <= 1'b0;
      r_start_press <= 1'b0;
      r_proto_error <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_space       <= w_space_nxt;
      r_up          <= w_up_nxt;
      r_down        <= w_down_nxt;
      r_enter       <= w_enter_nxt;
      r_event_valid <= w_evt;
      if (w_evt) begin
        r_event_break <= w_brk;
        r_event_ext   <= w_ext;
        r_event_code  <= ps2_data;
      end
      r_jump_held   <= w_jump_new;
      r_jump_press  <= ~w_jump_old & w_jump_new;
      r_start_press <= ~r_enter & w_enter_nxt;
      r_proto_error <= w_err;
    end
  end

  assign event_valid = r_event_valid;
  assign event_break = r_event_break;
  assign event_ext   = r_event_ext;
  assign event_code  = r_event_code;
  assign jump_held   = r_jump_held;
  assign duck_held   = r_down;
  assign start_held  = r_enter;
  assign jump_press  = r_jump_press;
  assign start_press = r_start_press;
  assign proto_error = r_proto_error;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker
// Scoreboard bench: the driver feeds bytes into a byte-list reference model
// that queues expected outputs with their cycle stamp; a monitor pops and
// compares whenever the tracker presents an event, error or press pulse.
module tb_ps2_key_tracker;

  localparam int P = 16;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_data_en = 1'b0;
  logic       event_valid, event_break, event_ext;
  logic [7:0] event_code;
  logic       jump_held, duck_held, start_held, jump_press, start_press, proto_error;

  ps2_key_tracker #(.PREFIX_TIMEOUT(P)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .ps2_data(ps2_data), .ps2_data_en(ps2_data_en),
    .event_valid(event_valid), .event_break(event_break), .event_ext(event_ext),
    .event_code(event_code), .jump_held(jump_held), .duck_held(duck_held),
    .start_held(start_held), .jump_press(jump_press), .start_press(start_press),
    .proto_error(proto_error)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         cyc;
    bit         err;
    bit         brk;
    bit         ext;
    logic [7:0] code;
    bit         jh, dh, sh, jp, sp;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: outstanding prefix bytes, idle cycles since the
  // last byte, and a held flag per {ext, code}.
  logic [7:0] pend[$];
  int         idle_cnt = 0;
  bit         held[512];
  logic [7:0] ign[7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic bit m_ignored(input logic [7:0] b);
    foreach (ign[i]) if (ign[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_jump();
    return held[{1'b0, 8'h29}] | held[{1'b1, 8'h75}];
  endfunction

  function automatic void m_push(input bit err, input bit brk, input bit ext,
                                 input logic [7:0] code, input bit jp, input bit sp);
    exp_t e;
    e.cyc = cyc + 1; e.err = err; e.brk = brk; e.ext = ext; e.code = code;
    e.jh = m_jump(); e.dh = held[{1'b1, 8'h72}]; e.sh = held[{1'b0, 8'h5A}];
    e.jp = jp; e.sp = sp;
    exp_q.push_back(e);
  endfunction

  function automatic void m_emit(input bit brk, input bit ext, input logic [7:0] b);
    bit j0, s0;
    j0 = m_jump();
    s0 = held[{1'b0, 8'h5A}];
    held[{ext, b}] = !brk;
    m_push(1'b0, brk, ext, b, !j0 && m_jump(), !s0 && held[{1'b0, 8'h5A}]);
  endfunction

  function automatic void m_step(input bit en, input logic [7:0] b);
    if (!en) begin
      if (pend.size() > 0) begin
        idle_cnt++;
        if (idle_cnt == P) begin
          m_push(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
          pend.delete();
          idle_cnt = 0;
        end
      end
      return;
    end
    idle_cnt = 0;
    if (pend.size() == 0) begin
      if (m_ignored(b)) return;
      if (b == 8'hE0 || b == 8'hF0) begin pend.push_back(b); return; end
      m_emit(1'b0, 1'b0, b);
    end else if (m_ignored(b)) begin
      m_push(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      pend.delete();
    end else if (b == 8'hF0 || b == 8'hE0) begin
      m_push(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      if (pend.size() == 1 && pend[0] == 8'hE0) begin
        if (b == 8'hF0) begin
          exp_q.delete(exp_q.size() - 1);  // E0 F0 is a legal prefix pair
          pend.push_back(b);
        end
      end else begin
        pend.delete();
      end
    end else begin
      m_emit(pend[pend.size()-1] == 8'hF0, pend[0] == 8'hE0, b);
      pend.delete();
    end
  endfunction

  task automatic drive_cycle(input bit en, input logic [7:0] b);
    @(negedge CLOCK_50);
    ps2_data_en = en;
    ps2_data    = en ? b : 8'h00;
    m_step(en, b);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) drive_cycle(1'b0, 8'h00);
    drive_cycle(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " event_valid"}, 32'(event_valid), 0);
    chk({tag, " event_break"}, 32'(event_break), 0);
    chk({tag, " event_ext"},   32'(event_ext), 0);
    chk({tag, " event_code"},  32'(event_code), 0);
    chk({tag, " jump_held"},   32'(jump_held), 0);
    chk({tag, " duck_held"},   32'(duck_held), 0);
    chk({tag, " start_held"},  32'(start_held), 0);
    chk({tag, " jump_press"},  32'(jump_press), 0);
    chk({tag, " start_press"}, 32'(start_press), 0);
    chk({tag, " proto_error"}, 32'(proto_error), 0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk(e.err ? "missing proto_error" : "missing event", 32'(cyc), 32'(e.cyc));
      end
      if (resetn && (event_valid || proto_error || jump_press || start_press)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected output", {28'd0, event_valid, proto_error, jump_press, start_press}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out cycle",   32'(cyc), 32'(e.cyc));
          chk("proto_error", 32'(proto_error), 32'(e.err));
          chk("event_valid", 32'(event_valid), 32'(!e.err));
          if (!e.err) begin
            chk("event_break", 32'(event_break), 32'(e.brk));
            chk("event_ext",   32'(event_ext),   32'(e.ext));
            chk("event_code",  32'(event_code),  32'(e.code));
          end
          chk("jump_held",   32'(jump_held),   32'(e.jh));
          chk("duck_held",   32'(duck_held),   32'(e.dh));
          chk("start_held",  32'(start_held),  32'(e.sh));
          chk("jump_press",  32'(jump_press),  32'(e.jp));
          chk("start_press", 32'(start_press), 32'(e.sp));
        end
      end
    end
  end

  // Driver
  logic [7:0] pool[12] = '{8'h29, 8'h75, 8'h72, 8'h5A, 8'hE0, 8'hF0,
                           8'hE0, 8'hF0, 8'h1C, 8'h00, 8'hE1, 8'hFA};

  initial begin
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;

    // Space make, repeats, break
    send(8'h29, 1); send(8'h29, 2); send(8'h29, 0);
    send(8'hF0, 1); send(8'h29, 0);
    // Up then Space then Up release: one jump_press only
    send(8'hE0, 2); send(8'h75, 0); send(8'h29, 1);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    idle(2);
    chk("jump held via space", 32'(jump_held), 1);
    send(8'hF0, 0); send(8'h29, 0);
    // Down, back-to-back
    send(8'hE0, 0); send(8'h72, 0); send(8'hE0, 0); send(8'hF0, 0); send(8'h72, 0);
    // Timeout then Enter
    send(8'hF0, 1); idle(P + 3); send(8'h5A, 0);
    // Byte arriving on the expiry cycle wins
    send(8'hF0, 1); send(8'h5A, P - 1);
    // Duplicate E0, then break-then-extended violation
    send(8'hE0, 1); send(8'hE0, 0); send(8'h75, 0);
    send(8'hF0, 1); send(8'hE0, 0);
    // Ignored bytes in idle and in a prefix state
    send(8'hFA, 1); send(8'hE0, 0); send(8'hAA, 0);
    // Reset mid-sequence while jump is held
    send(8'h29, 1); send(8'hE0, 0); send(8'hF0, 0);
    idle(2);
    chk("jump held before reset", 32'(jump_held), 1);
    @(negedge CLOCK_50);
    #1;
    resetn = 1'b0;
    pend.delete(); idle_cnt = 0; exp_q.delete();
    foreach (held[i]) held[i] = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge CLOCK_50);
    resetn = 1'b1;
    send(8'h75, 1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int r, gap;
      logic [7:0] b;
      r   = $urandom_range(0, 99);
      gap = (r < 50) ? 0 : (r < 90) ? $urandom_range(1, 4) : $urandom_range(P - 2, P + 2);
      b   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 11)];
      send(b, gap);
    end
    idle(P + 4);
    chk("scoreboard drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
